id_ex: RTL
==========

# id_ex

Pipeline register between decode and the ALU. It captures decoded operands, the ALU control code and the destination register under a valid/ready handshake. At capture it resolves operand forwarding from the two later stages, applies immediate substitution for op2, and presents registered `o_op1`/`o_op2`/`o_ctl` straight to the ALU inputs. Stall holds the stage; flush injects a bubble.

## Interface
- No parameters; data width fixed at 32, register index 5 bits, ALU control 4 bits (`ALU_*` codes from `defs.v`).
- `i_clk`  in  1  clock; all state updates on rising edge
- `i_rst_n`  in  1  reset, synchronous, active-low
- `i_valid`  in  1  decode presents an instruction
- `o_ready`  out  1  stage accepts this cycle (combinational)
- `i_ctl`  in  4  ALU control code
- `i_rs`, `i_rt`  in  5 each  source register indices
- `i_rs_val`, `i_rt_val`  in  32 each  register-file read values
- `i_imm`  in  32  extended immediate
- `i_use_imm`  in  1  op2 = `i_imm` instead of rt
- `i_rd`  in  5  destination register
- `i_wen`  in  1  instruction writes `i_rd`
- `i_stall`  in  1  downstream cannot take the held instruction
- `i_flush`  in  1  discard held and incoming instruction
- `i_fwd_ex_wen`, `i_fwd_ex_rd`, `i_fwd_ex_val`  in  1/5/32  producer one stage ahead (ALU result register)
- `i_fwd_mem_wen`, `i_fwd_mem_rd`, `i_fwd_mem_val`  in  1/5/32  producer two stages ahead
- `o_valid`  out  1  held instruction valid
- `o_op1`, `o_op2`  out  32 each  ALU operands
- `o_ctl`  out  4  ALU control; 4'hF is the bubble (ALU yields 0)
- `o_rd`  out  5  destination register
- `o_wen`  out  1  write enable; never 1 when `o_valid` = 0

## Operation
- `o_ready = ~(i_stall & o_valid)`, i.e. an empty stage always accepts.
- Per clock edge, in priority order:
  - `!i_rst_n`: clear the stage to the bubble (listed below).
  - `i_flush`: load the bubble. Flush beats stall and capture.
  - `i_stall & o_valid`: hold all outputs unchanged.
  - `i_valid`: capture.
  - Otherwise load the bubble.
- Bubble values: `o_valid`=0, `o_op1`=`o_op2`=0, `o_ctl`=4'hF, `o_rd`=0, `o_wen`=0.
- Forwarding, resolved at capture independently for rs and rt:
  - Source index 0 is never forwarded and always reads as 0, whatever `i_rs_val`/`i_rt_val` say.
  - First choice is the EX source: if `i_fwd_ex_wen` and `i_fwd_ex_rd` equals the index, use `i_fwd_ex_val`.
  - Otherwise the MEM source: if `i_fwd_mem_wen` and `i_fwd_mem_rd` equals the index, use `i_fwd_mem_val`.
  - Otherwise the register-file value.
  - EX wins when both sources match.
- `o_op1` is the resolved rs value. `o_op2` is `i_imm` if `i_use_imm`, else the resolved rt value.
- `o_wen` = `i_wen & (i_rd != 0)`; `o_rd` = `i_rd`.
- Operands are captured values. They are not re-resolved during a stall, because downstream stages also hold while stalled.

## Timing
- Latency is 1 cycle: inputs accepted at edge N appear on the outputs after edge N.
- Throughput is 1 instruction per cycle when `i_stall` = 0.
- Forwarding inputs are sampled at the same edge as the capture.
- Reset value of every output is the bubble. Reset asserted mid-stall clears the held instruction, and the stage accepts on the first cycle after release.
- `o_ready` depends only on `i_stall` and `o_valid`, never on `i_valid`, so there is no combinational loop with decode.

## Test plan
- Reset:
  - Drive `i_rst_n`=0 for 2 cycles with `i_valid`=1, `i_ctl`=ADD, `i_rs_val`=5 -> `o_valid`=0, `o_ctl`=4'hF, `o_op1`=0, `o_wen`=0.
  - Release -> next capture of 5+7 gives `o_op1`=5, `o_op2`=7, `o_ctl`=ADD one cycle later.
- Forwarding priority:
  - rs=3, EX(wen,rd=3,val=0xAAAA), MEM(wen,rd=3,val=0xBBBB), `i_rs_val`=0x1 -> `o_op1`=0xAAAA.
  - EX wen=0 -> 0xBBBB.
  - rs=0 with both sources at rd=0 -> `o_op1`=0.
- Immediate:
  - `i_use_imm`=1, `i_imm`=0xFFFF_FFF0, rt forwarded 0x1234 -> `o_op2`=0xFFFF_FFF0.
  - `i_wen`=1, `i_rd`=0 -> `o_wen`=0.
- Stall:
  - Capture A, then `i_stall`=1 for 3 cycles while decode offers B -> `o_ready`=0, outputs hold A.
  - Stall drops -> B appears next cycle, nothing lost or duplicated.
- Flush:
  - Flush with stall=1 and `i_valid`=1 in the same cycle -> bubble next cycle and `o_ready`=1.
  - Instruction offered during the flush cycle is dropped.
- Back-to-back:
  - 8 consecutive instructions, stall=0 -> 8 consecutive `o_valid` cycles in order, no bubbles.

Source files
------------

// File: rtl/id_ex.sv
// id_ex: decode-to-ALU pipeline register.
// Captures decoded operands, ALU control and destination under a valid/ready
// handshake, resolves EX/MEM forwarding and immediate substitution at capture,
// and presents registered operands straight to the ALU. Stall holds, flush
// injects a bubble (o_ctl = 4'hF, which the ALU turns into a zero result).
//
// Handshake: an instruction transfers from decode at a rising edge when
// i_valid & o_ready. o_ready = ~(i_stall & o_valid) depends only on local
// state and i_stall, never on i_valid, so decode may compute i_valid from
// o_ready without forming a loop. An empty stage always accepts. On the
// output side, o_valid marks the held instruction; while i_stall is high
// the held instruction and all outputs stay frozen.
module id_ex (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [3:0]  i_ctl,
  input  logic [4:0]  i_rs,
  input  logic [4:0]  i_rt,
  input  logic [31:0] i_rs_val,
  input  logic [31:0] i_rt_val,
  input  logic [31:0] i_imm,
  input  logic        i_use_imm,
  input  logic [4:0]  i_rd,
  input  logic        i_wen,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_fwd_ex_wen,
  input  logic [4:0]  i_fwd_ex_rd,
  input  logic [31:0] i_fwd_ex_val,
  input  logic        i_fwd_mem_wen,
  input  logic [4:0]  i_fwd_mem_rd,
  input  logic [31:0] i_fwd_mem_val,
  output logic        o_valid,
  output logic [31:0] o_op1,
  output logic [31:0] o_op2,
  output logic [3:0]  o_ctl,
  output logic [4:0]  o_rd,
  output logic        o_wen
);

  localparam logic [3:0] CTL_BUBBLE = 4'hF;

  logic        r_valid;
  logic [31:0] r_op1;
  logic [31:0] r_op2;
  logic [3:0]  r_ctl;
  logic [4:0]  r_rd;
  logic        r_wen;

  logic [31:0] w_rs_res;
  logic [31:0] w_rt_res;
  logic [31:0] w_op2;
  logic        w_wen;
  logic        w_hold;

  // A stage is held only when it has something to hold; empty stages accept.
  assign w_hold  = i_stall & r_valid;
  assign o_ready = ~w_hold;

  // Resolve rs: register 0 is hard zero, then EX beats MEM beats register file.
  always_comb begin
    w_rs_res = i_rs_val;
    if (i_rs == 5'd0) begin
      w_rs_res = 32'd0;
    end else if (i_fwd_ex_wen && (i_fwd_ex_rd == i_rs)) begin
      w_rs_res = i_fwd_ex_val;
    end else if (i_fwd_mem_wen && (i_fwd_mem_rd == i_rs)) begin
      w_rs_res = i_fwd_mem_val;
    end
  end

  // Resolve rt with the same priority as rs.
  always_comb begin
    w_rt_res = i_rt_val;
    if (i_rt == 5'd0) begin
      w_rt_res = 32'd0;
    end else if (i_fwd_ex_wen && (i_fwd_ex_rd == i_rt)) begin
      w_rt_res = i_fwd_ex_val;
    end else if (i_fwd_mem_wen && (i_fwd_mem_rd == i_rt)) begin
      w_rt_res = i_fwd_mem_val;
    end
  end

  // Immediate substitution for op2 and suppression of writes to register 0.
  always_comb begin
    w_op2 = i_use_imm ? i_imm : w_rt_res;
    w_wen = i_wen & (i_rd != 5'd0);
  end

  // Stage register: reset/flush/idle load the bubble, stall holds, else capture.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      r_valid <= 1'b0;
      r_op1   <= 32'd0;
      r_op2   <= 32'd0;
      r_ctl   <= CTL_BUBBLE;
      r_rd    <= 5'd0;
      r_wen   <= 1'b0;
    end else if (w_hold) begin
      r_valid <= r_valid;
      r_op1   <= r_op1;
      r_op2   <= r_op2;
      r_ctl   <= r_ctl;
      r_rd    <= r_rd;
      r_wen   <= r_wen;
    end else if (i_valid) begin
      r_valid <= 1'b1;
      r_op1   <= w_rs_res;
      r_op2   <= w_op2;
      r_ctl   <= i_ctl;
      r_rd    <= i_rd;
      r_wen   <= w_wen;
    end else begin
      r_valid <= 1'b0;
      r_op1   <= 32'd0;
      r_op2   <= 32'd0;
      r_ctl   <= CTL_BUBBLE;
      r_rd    <= 5'd0;
      r_wen   <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_op1   = r_op1;
  assign o_op2   = r_op2;
  assign o_ctl   = r_ctl;
  assign o_rd    = r_rd;
  assign o_wen   = r_wen;

endmodule
